// File: rtl/vasip_mem_pkg.sv
// Shared constants and types for the result-memory reader.
package vasip_mem_pkg;

  localparam int unsigned MEM_DEPTH  = 128;
  localparam int unsigned MEM_BURST  = 4;
  localparam int unsigned MEM_WORD_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StSend,
    StDone
  } reader_state_e;

endpackage

// File: rtl/out_mem_burst_buf.sv
// Four-word burst buffer: parallel load, word index and output word select.
module out_mem_burst_buf
  import vasip_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  advance_i,
  input  logic [MEM_WORD_W-1:0] word0_i,
  input  logic [MEM_WORD_W-1:0] word1_i,
  input  logic [MEM_WORD_W-1:0] word2_i,
  input  logic [MEM_WORD_W-1:0] word3_i,
  output logic [MEM_WORD_W-1:0] data_o,
  output logic                  last_o
);

  logic [MEM_BURST-1:0][MEM_WORD_W-1:0] words_q, words_d;
  logic [1:0]                           idx_q, idx_d;

  always_comb begin
    words_d = words_q;
    idx_d   = idx_q;
    if (load_i) begin
      words_d[0] = word0_i;
      words_d[1] = word1_i;
      words_d[2] = word2_i;
      words_d[3] = word3_i;
      idx_d      = '0;
    end else if (advance_i) begin
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      words_q <= '0;
      idx_q   <= '0;
    end else begin
      words_q <= words_d;
      idx_q   <= idx_d;
    end
  end

  assign data_o = words_q[idx_q];
  assign last_o = (idx_q == 2'(MEM_BURST - 1));

endmodule

// File: rtl/out_mem_reader.sv
// Drains the result memory in 4-word bursts onto a valid/ready stream.
// Define OUT_MEM_READER_CHKSUM_EN to add the chksum output (running sum of sent words).
module out_mem_reader
  import vasip_mem_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_DEPTH,
  parameter int unsigned BURST = MEM_BURST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] last_addr,
  output logic [31:0] addr,
  input  logic [31:0] sumr1,
  input  logic [31:0] sumr2,
  input  logic [31:0] sumr3,
  input  logic [31:0] sumr4,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
`ifdef OUT_MEM_READER_CHKSUM_EN
  ,
  output logic [31:0] chksum
`endif
);

  localparam logic [31:0] DepthW = 32'(DEPTH);
  localparam logic [31:0] BurstW = 32'(BURST);

  reader_state_e state_q, state_d;
  logic [31:0]   rd_addr_q, rd_addr_d;
  logic [31:0]   end_addr_q, end_addr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   last_aligned;
  logic [31:0]   rd_addr_next;
  logic          load;
  logic          xfer;
  logic          buf_last;

  assign last_aligned = {last_addr[31:2], 2'b00};
  assign rd_addr_next = rd_addr_q + BurstW;
  assign xfer         = (state_q == StSend) && out_ready;

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    end_addr_d = end_addr_q;
    addr_d     = addr_q;
    load       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          end_addr_d = (last_aligned > DepthW) ? DepthW : last_aligned;
          rd_addr_d  = '0;
          addr_d     = '0;
          state_d    = (end_addr_d == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        load    = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (xfer && buf_last) begin
          rd_addr_d = rd_addr_next;
          if (rd_addr_next >= end_addr_q) begin
            state_d = StDone;
          end else begin
            // addr only moves when a new fetch is due, so it holds the last base otherwise
            addr_d  = rd_addr_next;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rd_addr_q  <= '0;
      end_addr_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      end_addr_q <= end_addr_d;
      addr_q     <= addr_d;
    end
  end

  out_mem_burst_buf u_burst_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .advance_i (xfer),
    .word0_i   (sumr1),
    .word1_i   (sumr2),
    .word2_i   (sumr3),
    .word3_i   (sumr4),
    .data_o    (out_data),
    .last_o    (buf_last)
  );

  assign addr      = addr_q;
  assign out_valid = (state_q == StSend);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

`ifdef OUT_MEM_READER_CHKSUM_EN
  logic [31:0] chksum_q, chksum_d;

  always_comb begin
    chksum_d = chksum_q;
    if ((state_q == StIdle) && start) begin
      chksum_d = '0;
    end else if (xfer) begin
      chksum_d = chksum_q + out_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chksum_q <= '0;
    end else begin
      chksum_q <= chksum_d;
    end
  end

  assign chksum = chksum_q;
`endif

endmodule

// File: tb/tb_out_mem_reader.sv
// Scoreboard bench for out_mem_reader: expected words queued at start, popped on transfer.
module tb_out_mem_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] last_addr;
  logic [31:0] addr;
  logic [31:0] sumr1, sumr2, sumr3, sumr4;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
`ifdef OUT_MEM_READER_CHKSUM_EN
  logic [31:0] chksum;
  logic [31:0] chk_at_done;
`endif

  logic [31:0] mem [256];
  logic [31:0] exp_q [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_mode = 0;
  int rp = 0;
  int first_valid_cyc, done_cyc, done_cnt, valid_cnt, xfer_cnt, fetch_cnt;
  int start_cyc;
  logic        hold_pending = 1'b0;
  logic [31:0] held_data = '0;

  out_mem_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .last_addr (last_addr),
    .addr      (addr),
    .sumr1     (sumr1),
    .sumr2     (sumr2),
    .sumr3     (sumr3),
    .sumr4     (sumr4),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef OUT_MEM_READER_CHKSUM_EN
    ,
    .chksum    (chksum)
`endif
  );

  assign sumr1 = mem[addr[7:0]];
  assign sumr2 = mem[8'(addr + 32'd1)];
  assign sumr3 = mem[8'(addr + 32'd2)];
  assign sumr4 = mem[8'(addr + 32'd3)];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ready pattern 1,0,0,1 repeating in mode 1
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else                 out_ready = ((rp % 4) == 0) || ((rp % 4) == 3);
    rp++;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (hold_pending) check_val("hold_stable", out_data, held_data);
      end
      hold_pending = 1'b0;
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check_val("sb_nonempty", 32'(exp_q.size()), 32'd1);
        else check_val("word", out_data, exp_q.pop_front());
      end else if (out_valid) begin
        hold_pending = 1'b1;
        held_data    = out_data;
      end
      if (busy && !out_valid && !done) fetch_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
`ifdef OUT_MEM_READER_CHKSUM_EN
        chk_at_done = chksum;
`endif
      end
    end
  end

  task automatic clear_stats();
    first_valid_cyc = -1;
    done_cyc        = -1;
    done_cnt        = 0;
    valid_cnt       = 0;
    xfer_cnt        = 0;
    fetch_cnt       = 0;
    hold_pending    = 1'b0;
  endtask

  task automatic do_drain(input logic [31:0] la, input int mode, input bit poke);
    logic [31:0] endv;
    endv = {la[31:2], 2'b00};
    if (endv > 32'd128) endv = 32'd128;
    clear_stats();
    for (int i = 0; i < int'(endv); i++) exp_q.push_back(mem[i]);
    ready_mode = mode;
    rp = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    last_addr = la;
    start_cyc = cyc;
    for (int i = 0; i < 1500 && done_cyc < 0; i++) begin
      @(posedge clk); #1;
      start     = poke && (i == 3);
      last_addr = 32'hFFFF_FFF0;
    end
    start = 1'b0;
    check_val("done_seen", 32'(done_cyc >= 0), 32'd1);
    check_val("xfer_count", 32'(xfer_cnt), endv);
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    check_val("done_once", 32'(done_cnt), 32'd1);
    if (mode == 0) begin
      check_val("valid_cycles", 32'(valid_cnt), endv);
      check_val("done_latency", 32'(done_cyc - start_cyc), 32'd1 + (endv / 4) * 5);
      if (endv != 0) check_val("first_latency", 32'(first_valid_cyc - start_cyc), 32'd2);
    end
    repeat (2) @(posedge clk);
    #1;
    check_val("idle_after", {31'd0, busy}, 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    last_addr = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h10 + 32'(i);
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_addr", addr, 32'd0);
    check_val("rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_data", out_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 8 words, ready held high: 10-cycle window from first valid to done
    do_drain(32'd8, 0, 1'b0);
    check_val("window", 32'(done_cyc - first_valid_cyc + 1), 32'd10);
    check_val("fetches_8", 32'(fetch_cnt), 32'd2);

    // Backpressure with a start poked mid-drain
    do_drain(32'd8, 1, 1'b1);

    // Empty drain
    do_drain(32'd0, 0, 1'b0);
    check_val("empty_valid", 32'(valid_cnt), 32'd0);

    // Clamp to depth, and unaligned end address
    do_drain(32'd200, 0, 1'b0);
    check_val("fetches_128", 32'(fetch_cnt), 32'd32);
    do_drain(32'd6, 0, 1'b0);
    check_val("fetches_4", 32'(fetch_cnt), 32'd1);

    // Reset after the third word of an 8-word drain
    clear_stats();
    for (int i = 0; i < 8; i++) exp_q.push_back(mem[i]);
    ready_mode = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    last_addr = 32'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && xfer_cnt < 3; i++) @(posedge clk);
    check_val("pre_reset_xfers", 32'(xfer_cnt), 32'd3);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_val("mid_rst_addr", addr, 32'd0);
    check_val("mid_rst_data", out_data, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_drain(32'd8, 0, 1'b0);

`ifdef OUT_MEM_READER_CHKSUM_EN
    mem[0] = 32'hFFFF_FFFF;
    mem[1] = 32'd1;
    mem[2] = 32'd2;
    mem[3] = 32'd3;
    do_drain(32'd4, 0, 1'b1);
    check_val("chksum_done", chk_at_done, 32'h0000_0005);
    check_val("chksum_hold", chksum, 32'h0000_0005);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
